// File: rtl/wave_pkg.sv
// Shared types and default sizes for the multi-channel waveform sequencer.
package wave_pkg;

  localparam int BIT_LEN_DEF = 823;
  localparam int SEQ_LEN_DEF = 8;

  typedef enum logic [1:0] {
    PAT_SYM0 = 2'd0,
    PAT_SYM1 = 2'd1,
    PAT_QMOD = 2'd2
  } pat_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/wave_pat_mem.sv
// One-bit-wide pattern store: single write port, combinational read, no reset.
module wave_pat_mem #(
  parameter int BIT_LEN = 823,
  parameter int CNT_W   = $clog2(BIT_LEN)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [CNT_W-1:0] waddr,
  input  logic             wdata,
  input  logic [CNT_W-1:0] raddr,
  output logic             rdata
);

  logic mem [BIT_LEN];

  // Out-of-range addresses are dropped so a non-power-of-two length never aliases.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < BIT_LEN)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wave_seq_gen.sv
// Multi-channel waveform sequencer: plays per-channel symbol words through shared
// sym0/sym1 bit patterns with a common QMOD envelope, one-shot or continuous.
module wave_seq_gen
  import wave_pkg::*;
#(
  parameter int BIT_LEN = BIT_LEN_DEF,
  parameter int SEQ_LEN = SEQ_LEN_DEF,
  parameter int NUM_CH  = 1,
  parameter int CNT_W   = $clog2(BIT_LEN)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      loop,
  input  logic [NUM_CH*SEQ_LEN-1:0] seq,
  input  logic                      pat_we,
  input  logic [1:0]                pat_sel,
  input  logic [CNT_W-1:0]          pat_addr,
  input  logic                      pat_data,
  output logic [NUM_CH-1:0]         GDS,
  output logic                      QMOD,
  output logic                      busy,
  output logic                      frame,
  output logic                      done,
  output state_e                    state_dbg
);

  localparam int SYM_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  state_e                    state_q, state_d;
  logic [SYM_W-1:0]          sym_q, sym_d;
  logic [CNT_W-1:0]          bit_q, bit_d;
  logic                      loop_q, loop_d;
  logic [NUM_CH*SEQ_LEN-1:0] seq_q, seq_d;
  logic                      pend_q, pend_d;
  logic [NUM_CH-1:0]         gds_d;
  logic                      qmod_d, frame_d, busy_d;

  logic              wr_ok;
  logic              sym0_bit, sym1_bit, qmod_bit;
  logic [NUM_CH-1:0] elem;

  assign wr_ok = pat_we && (state_q == IDLE);

  wave_pat_mem #(.BIT_LEN(BIT_LEN), .CNT_W(CNT_W)) u_sym0 (
    .clk   (clk),
    .we    (wr_ok && (pat_sel == PAT_SYM0)),
    .waddr (pat_addr),
    .wdata (pat_data),
    .raddr (bit_q),
    .rdata (sym0_bit)
  );

  wave_pat_mem #(.BIT_LEN(BIT_LEN), .CNT_W(CNT_W)) u_sym1 (
    .clk   (clk),
    .we    (wr_ok && (pat_sel == PAT_SYM1)),
    .waddr (pat_addr),
    .wdata (pat_data),
    .raddr (bit_q),
    .rdata (sym1_bit)
  );

  wave_pat_mem #(.BIT_LEN(BIT_LEN), .CNT_W(CNT_W)) u_qmod (
    .clk   (clk),
    .we    (wr_ok && (pat_sel == PAT_QMOD)),
    .waddr (pat_addr),
    .wdata (pat_data),
    .raddr (bit_q),
    .rdata (qmod_bit)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SEQ_LEN-1:0] ch_seq;
    assign ch_seq  = seq_q[c*SEQ_LEN +: SEQ_LEN];
    assign elem[c] = ch_seq[sym_q] ? sym1_bit : sym0_bit;
  end

  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    bit_d   = bit_q;
    loop_d  = loop_q;
    seq_d   = seq_q;
    pend_d  = 1'b0;
    gds_d   = '0;
    qmod_d  = 1'b0;
    frame_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        sym_d = '0;
        bit_d = '0;
        if (start && !stop) begin
          state_d = RUN;
          loop_d  = loop;
          seq_d   = seq;
        end
      end
      RUN: begin
        gds_d   = elem;
        qmod_d  = qmod_bit;
        frame_d = (sym_q == '0) && (bit_q == '0);
        if (stop) begin
          state_d = IDLE;
          sym_d   = '0;
          bit_d   = '0;
        end else if (bit_q == CNT_W'(BIT_LEN - 1)) begin
          bit_d = '0;
          if (sym_q == SYM_W'(SEQ_LEN - 1)) begin
            sym_d = '0;
            // Continuous mode picks up a fresh sequence word at every frame wrap.
            if (loop_q) begin
              seq_d = seq;
            end else begin
              state_d = IDLE;
              pend_d  = 1'b1;
            end
          end else begin
            sym_d = sym_q + 1'b1;
          end
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sym_q   <= '0;
      bit_q   <= '0;
      loop_q  <= 1'b0;
      seq_q   <= '0;
      pend_q  <= 1'b0;
      GDS     <= '0;
      QMOD    <= 1'b0;
      busy    <= 1'b0;
      frame   <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      bit_q   <= bit_d;
      loop_q  <= loop_d;
      seq_q   <= seq_d;
      pend_q  <= pend_d;
      GDS     <= gds_d;
      QMOD    <= qmod_d;
      busy    <= busy_d;
      frame   <= frame_d;
      done    <= pend_q;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_wave_seq_gen.sv
// Randomized and directed bench for wave_seq_gen against a frame-level reference model.
module tb_wave_seq_gen;
  import wave_pkg::*;

  localparam int BL = 8;
  localparam int SL = 4;
  localparam int NC = 2;
  localparam int FL = BL * SL;
  localparam int CW = $clog2(BL);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start, stop, loop;
  logic [NC*SL-1:0] seq;
  logic             pat_we;
  logic [1:0]       pat_sel;
  logic [CW-1:0]    pat_addr;
  logic             pat_data;
  logic [NC-1:0]    GDS;
  logic             QMOD, busy, frame, done;
  state_e           state_dbg;

  wave_seq_gen #(.BIT_LEN(BL), .SEQ_LEN(SL), .NUM_CH(NC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .stop      (stop),
    .loop      (loop),
    .seq       (seq),
    .pat_we    (pat_we),
    .pat_sel   (pat_sel),
    .pat_addr  (pat_addr),
    .pat_data  (pat_data),
    .GDS       (GDS),
    .QMOD      (QMOD),
    .busy      (busy),
    .frame     (frame),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model state and scoreboard
  logic m_sym0 [BL];
  logic m_sym1 [BL];
  logic m_qmod [BL];
  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver: one pattern write in IDLE; the model keeps only writes the block should accept.
  task automatic write_pat(input int sel, input int addr, input logic data);
    pat_we   = 1'b1;
    pat_sel  = 2'(sel);
    pat_addr = CW'(addr);
    pat_data = data;
    step();
    pat_we = 1'b0;
    case (sel)
      0: m_sym0[addr] = data;
      1: m_sym1[addr] = data;
      2: m_qmod[addr] = data;
      default: ;
    endcase
  endtask

  // Expected {done, frame, busy, QMOD, GDS} k cycles after the start edge.
  // fin is the last cycle showing an element; frame 0 plays sa, later frames sb.
  function automatic logic [5:0] model_word(int k, int fin, logic [7:0] sa, logic [7:0] sb,
                                            logic stopped);
    logic [7:0]    sw;
    logic [NC-1:0] g;
    logic          q, fr, bz, dn;
    int            idx, e, s, b;
    g = '0; q = 1'b0; fr = 1'b0; bz = 1'b0; dn = 1'b0;
    if (k <= fin) begin
      idx = k - 1;
      e   = idx % FL;
      s   = e / BL;
      b   = e % BL;
      sw  = (idx < FL) ? sa : sb;
      for (int c = 0; c < NC; c++) g[c] = sw[c*SL + s] ? m_sym1[b] : m_sym0[b];
      q  = m_qmod[b];
      fr = (e == 0);
      bz = (k < fin);
    end else begin
      dn = (k == fin + 1) && !stopped;
    end
    return {dn, fr, bz, q, g};
  endfunction

  // Plays one run: start with sa, switch the seq input to sb mid-frame, optional stop,
  // an ignored start/loop change while running and an optional write attempt while busy.
  task automatic play(input logic [7:0] sa, input logic [7:0] sb, input logic lp,
                      input int stop_at, input logic wr_busy);
    int fin;
    logic [5:0] got_w;
    fin  = (stop_at > 0) ? stop_at : FL;
    seq  = sa;
    loop = lp;
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_e0", busy, 1);
    for (int k = 1; k <= fin + 3; k++) begin
      stop  = (k == stop_at);
      start = (k == 7) && (k < fin);
      loop  = start ? ~lp : lp;
      if (k == 5) seq = sb;
      pat_we = wr_busy && (k == 3) && (k < fin);
      if (pat_we) begin
        pat_sel  = 2'($urandom_range(0, 3));
        pat_addr = CW'($urandom_range(0, BL - 1));
        pat_data = 1'($urandom_range(0, 1));
      end
      exp_q.push_back(model_word(k, fin, sa, sb, stop_at > 0));
      step();
      got_w = {done, frame, busy, QMOD, GDS};
      check($sformatf("cyc%0d", k), got_w, exp_q.pop_front());
    end
    start  = 1'b0;
    stop   = 1'b0;
    pat_we = 1'b0;
  endtask

  initial begin
    logic [7:0] p;
    logic [7:0] sa, sb;
    logic       lp;
    int         sa_stop;
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0; seq = '0;
    pat_we = 1'b0; pat_sel = '0; pat_addr = '0; pat_data = 1'b0;
    repeat (3) step();
    check("rst_out", {done, frame, busy, QMOD, GDS}, 0);
    check("rst_state", state_dbg, IDLE);
    reset_n = 1'b1;
    step();

    p = 8'b11110000;
    for (int i = 0; i < BL; i++) begin
      write_pat(0, i, p[7-i]);
      write_pat(1, i, ~p[7-i]);
      write_pat(2, i, 1'b1);
    end

    play(8'h05, 8'h05, 1'b0, 0, 1'b0);
    play(8'h05, 8'h03, 1'b1, 70, 1'b0);
    play(8'h05, 8'h05, 1'b0, 10, 1'b0);

    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", busy, 0);
    check("ss_state", state_dbg, IDLE);
    step();
    check("ss_out", {done, frame, QMOD, GDS}, 0);

    play(8'h5A, 8'h5A, 1'b0, 0, 1'b1);
    for (int i = 0; i < BL; i += 2) write_pat(3, i, ~m_sym0[i]);
    play(8'hF0, 8'hF0, 1'b0, 0, 1'b0);

    seq = 8'h3C; loop = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    #2 reset_n = 1'b0;
    #1;
    check("arst_out", {done, frame, busy, QMOD, GDS}, 0);
    check("arst_state", state_dbg, IDLE);
    step();
    #2 reset_n = 1'b1;
    step();
    play(8'h3C, 8'h3C, 1'b0, 0, 1'b0);

    repeat (6) begin
      for (int i = 0; i < BL; i++) begin
        write_pat(0, i, 1'($urandom_range(0, 1)));
        write_pat(1, i, 1'($urandom_range(0, 1)));
        write_pat(2, i, 1'($urandom_range(0, 1)));
      end
      sa = 8'($urandom);
      sb = 8'($urandom);
      lp = 1'($urandom_range(0, 1));
      if (lp) sa_stop = $urandom_range(40, 100);
      else    sa_stop = $urandom_range(0, 1) ? 0 : $urandom_range(8, 31);
      play(sa, sb, lp, sa_stop, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_seq_gen.md
# wave_seq_gen

Parametrised multi-channel waveform sequencer, successor to the fixed single-channel GDS/QMOD generator. Three writable bit-pattern memories hold symbol-0, symbol-1 and QMOD envelopes. Each channel plays a per-channel sequence word one pattern at a time, with start/stop control and one-shot or continuous mode. It sits between the clock wizard output and the GDS/QMOD pins.

## Interface
- BIT_LEN, 823, pattern length in bits (cycles per symbol)
- SEQ_LEN, 8, symbols per frame
- NUM_CH, 1, independent GDS channels sharing the pattern memories and QMOD
- CNT_W, $clog2(BIT_LEN), width of pattern address (derived)
- clk  in  1  clock; one clock domain
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a frame from IDLE
- stop  in  1  pulse; aborts playback
- loop  in  1  1 = continuous, 0 = one-shot; sampled with start
- seq  in  NUM_CH*SEQ_LEN  symbol bits; channel c symbol s = seq[c*SEQ_LEN+s]
- pat_we  in  1  pattern write strobe
- pat_sel  in  2  0 = sym0, 1 = sym1, 2 = QMOD, 3 = reserved (write ignored)
- pat_addr  in  CNT_W  bit index
- pat_data  in  1  bit value
- GDS  out  NUM_CH  per-channel waveform
- QMOD  out  1  modulation envelope
- busy  out  1  high in RUN
- frame  out  1  one-cycle pulse with element (0,0) of every frame
- done  out  1  one-cycle pulse at one-shot completion

## Operation
- States: IDLE, RUN.
- IDLE: counters sym = 0, bit = 0.
- IDLE→RUN on start & !stop. At the same edge, latch loop and seq into internal registers.
- In RUN, each edge registers the outputs for the current element:
  - GDS[c] = (seq_r[c*SEQ_LEN+sym] ? sym1 : sym0)[bit]
  - QMOD = qmod[bit]
  - Then advance bit. When bit = BIT_LEN-1, bit wraps to 0 and sym advances. When sym = SEQ_LEN-1, sym wraps to 0.
- End of frame, one-shot: go to IDLE. The next edge registers GDS = 0, QMOD = 0, done = 1.
- End of frame, loop: wrap to (0,0) with no gap cycle. Re-latch seq at the wrap. loop stays as latched.
- stop in RUN: go to IDLE. The next edge registers outputs = 0. No done pulse.
- start while in RUN: ignored.
- start and stop high in the same IDLE cycle: stop wins; the block stays in IDLE.
- pattern writes:
  - Accepted only in IDLE.
  - Ignored when pat_addr ≥ BIT_LEN or pat_sel = 3.
- Pattern memories are not reset; their contents survive reset_n.
- Reset (any time, including mid-frame): state IDLE, counters 0. GDS, QMOD, busy, frame and done all 0 immediately.

## Timing
- Edge E0 samples start. Element (s,b) is visible on GDS/QMOD from edge E(1 + s·BIT_LEN + b).
- Frame length: SEQ_LEN·BIT_LEN cycles.
- busy: rises at E0. In one-shot it falls at the edge that registers the last element, so it is low while the last element is visible.
- frame: high for the single cycle element (0,0) is visible.
- done: high for one cycle, starting at E(1 + SEQ_LEN·BIT_LEN).
- Pattern write at edge W is readable by a frame started at W+1 or later.
- Memory read is combinational from the registered counters. Every output is a flop.

## Structure
- Package wave_pkg holds:
  - pat_sel_e {PAT_SYM0, PAT_SYM1, PAT_QMOD}
  - state_e {IDLE, RUN}
  - Default BIT_LEN and SEQ_LEN constants
- Sub-module wave_pat_mem: BIT_LEN×1 storage, one write port, asynchronous read. Instantiated three times.
- Top level: FSM, bit and sym counters, per-channel output mux.

## Test plan
- BIT_LEN=8, SEQ_LEN=4, sym0=8'b11110000 (bit 0 = MSB written first), sym1=inverse, qmod all 1, seq=4'b0101, one-shot start:
  - GDS shows sym1, sym0, sym1, sym0 (sym0 = symbol bit 0 first).
  - QMOD is high for 32 cycles.
  - done pulses at cycle 33 after the start edge, and busy is low at that point.
- Same setup with loop=1, seq changed to 4'b0011 mid-frame:
  - Frame 2 plays the new sequence.
  - frame pulses every 32 cycles with no gap.
- stop asserted at cycle 10 of a frame: outputs are 0 from cycle 11, no done pulse, busy low.
- reset_n dropped mid-frame:
  - All outputs are 0 asynchronously.
  - After release, a start replays from (0,0) using the unchanged pattern contents.
- Write attempted while busy, and a write with pat_sel=3: memory contents unchanged on the next one-shot.
- NUM_CH=2, seq={4'b1111, 4'b0000}: ch1 shows sym1 throughout while ch0 shows sym0, cycle-aligned.
